// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcode encoding and the ID/EX control bundle used by the
// ID/EX pipeline register and its forwarding muxes.
package id_ex_stage_pkg;

    localparam int unsigned WORD_BUS_W     = 32;
    localparam int unsigned REG_ADDR_BUS_W = 5;
    localparam int unsigned SHAMT_W        = 5;

    typedef enum logic [4:0] {
        AluOpNop  = 5'd0,
        AluOpAdd  = 5'd1,
        AluOpSub  = 5'd2,
        AluOpAnd  = 5'd3,
        AluOpOr   = 5'd4,
        AluOpXor  = 5'd5,
        AluOpNor  = 5'd6,
        AluOpSlt  = 5'd7,
        AluOpSltu = 5'd8,
        AluOpSll  = 5'd9,
        AluOpSrl  = 5'd10,
        AluOpSra  = 5'd11,
        AluOpLui  = 5'd12
    } alu_op_e;

    // All-zero value of this bundle is a bubble.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic alu_src;
        logic shift;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way operand select: EX/MEM result, then MEM/WB data, then the
// registered value. Register $0 never takes a forwarded value.
module id_ex_stage_fwd_mux #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] reg_addr_i,
    input  logic [WORD_W-1:0] reg_data_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_dest_i,
    input  logic [WORD_W-1:0] mem_data_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_dest_i,
    input  logic [WORD_W-1:0] wb_data_i,
    output logic [WORD_W-1:0] fwd_data_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write_i && (mem_dest_i != '0) && (mem_dest_i == reg_addr_i);
    assign wb_hit  = wb_reg_write_i && (wb_dest_i != '0) && (wb_dest_i == reg_addr_i);

    always_comb begin
        fwd_data_o = reg_data_i;
        if (mem_hit) begin
            fwd_data_o = mem_data_i;
        end else if (wb_hit) begin
            fwd_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion and
// forwarded ALU operands / store data for the EX stage.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_BUS_W,
    parameter int unsigned REG_AW = REG_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] id_pc,
    input  logic [WORD_W-1:0] id_rs_data,
    input  logic [WORD_W-1:0] id_rt_data,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [SHAMT_W-1:0] id_shamt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [4:0]        id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_shift,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [WORD_W-1:0] mem_alu_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [WORD_W-1:0] wb_data,
    output logic              stall_o,
    output logic [WORD_W-1:0] ex_pc,
    output logic [4:0]        ex_alu_ctrl,
    output logic [WORD_W-1:0] ex_data_in1,
    output logic [WORD_W-1:0] ex_data_in2,
    output logic [WORD_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch
);

    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [4:0]         alu_ctrl_q, alu_ctrl_d;
    logic [REG_AW-1:0]  rs_q, rs_d;
    logic [REG_AW-1:0]  rt_q, rt_d;
    logic [WORD_W-1:0]  rs_data_q, rs_data_d;
    logic [WORD_W-1:0]  rt_data_q, rt_data_d;
    logic [WORD_W-1:0]  imm_q, imm_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [REG_AW-1:0]  dest_q, dest_d;
    ctrl_t              ctrl_q, ctrl_d;

    logic              raw_hazard;
    logic              capture;
    logic [WORD_W-1:0] rs_wt_data;
    logic [WORD_W-1:0] rt_wt_data;
    logic [WORD_W-1:0] rs_fwd;
    logic [WORD_W-1:0] rt_fwd;

    // Load in EX whose target is read by the instruction currently in ID.
    assign raw_hazard = ctrl_q.mem_read && (rt_q != '0) &&
                        ((id_uses_rs && (id_rs == rt_q)) || (id_uses_rt && (id_rt == rt_q)));
    assign stall_o    = raw_hazard && !flush_i;
    assign capture    = !flush_i && !stall_o;

    // Register-file write-through for a WB write landing in the same cycle as the read.
    assign rs_wt_data = (wb_reg_write && (wb_dest != '0) && (wb_dest == id_rs)) ? wb_data
                                                                                 : id_rs_data;
    assign rt_wt_data = (wb_reg_write && (wb_dest != '0) && (wb_dest == id_rt)) ? wb_data
                                                                                 : id_rt_data;

    always_comb begin
        pc_d       = '0;
        alu_ctrl_d = '0;
        rs_d       = '0;
        rt_d       = '0;
        rs_data_d  = '0;
        rt_data_d  = '0;
        imm_d      = '0;
        shamt_d    = '0;
        dest_d     = '0;
        ctrl_d     = '0;
        if (capture) begin
            pc_d       = id_pc;
            alu_ctrl_d = id_alu_ctrl;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rs_data_d  = rs_wt_data;
            rt_data_d  = rt_wt_data;
            imm_d      = id_imm;
            shamt_d    = id_shamt;
            dest_d     = id_reg_dst ? id_rd : id_rt;
            ctrl_d     = '{mem_read:   id_mem_read,
                           mem_write:  id_mem_write,
                           reg_write:  id_reg_write,
                           mem_to_reg: id_mem_to_reg,
                           branch:     id_branch,
                           alu_src:    id_alu_src,
                           shift:      id_shift};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            alu_ctrl_q <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            dest_q     <= '0;
            ctrl_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            alu_ctrl_q <= alu_ctrl_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            dest_q     <= dest_d;
            ctrl_q     <= ctrl_d;
        end
    end

    id_ex_stage_fwd_mux #(
        .WORD_W (WORD_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .reg_addr_i      (rs_q),
        .reg_data_i      (rs_data_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_dest_i      (mem_dest),
        .mem_data_i      (mem_alu_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_dest_i       (wb_dest),
        .wb_data_i       (wb_data),
        .fwd_data_o      (rs_fwd)
    );

    id_ex_stage_fwd_mux #(
        .WORD_W (WORD_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .reg_addr_i      (rt_q),
        .reg_data_i      (rt_data_q),
        .mem_reg_write_i (mem_reg_write),
        .mem_dest_i      (mem_dest),
        .mem_data_i      (mem_alu_result),
        .wb_reg_write_i  (wb_reg_write),
        .wb_dest_i       (wb_dest),
        .wb_data_i       (wb_data),
        .fwd_data_o      (rt_fwd)
    );

    // Shifts take the amount on DataIn1 and the value on DataIn2.
    assign ex_data_in1   = ctrl_q.shift ? {{(WORD_W-SHAMT_W){1'b0}}, shamt_q} : rs_fwd;
    assign ex_data_in2   = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign ex_store_data = rt_fwd;

    assign ex_pc         = pc_q;
    assign ex_alu_ctrl   = alu_ctrl_q;
    assign ex_dest       = dest_q;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, async reset
// sequence, then randomized cycles against a behavioural pipeline model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct {
        logic        flush;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt, alu_ctrl;
        logic        uses_rs, uses_rt, alu_src, reg_dst, shift;
        logic        mem_read, mem_write, reg_write, mem_to_reg, branch;
        logic        mem_rw;
        logic [4:0]  mem_dest;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_dest;
        logic [31:0] wb_data;
    } vin_t;

    typedef struct {
        logic        stall;
        logic [31:0] d1, d2, sd;
        logic [4:0]  dest;
        logic        rw, mr;
    } exp_t;

    typedef struct {
        vin_t in;
        exp_t ex;
    } row_t;

    // Instruction sitting in EX, as the model sees it.
    typedef struct {
        logic [31:0] pc, rs_val, rt_val, imm;
        logic [4:0]  alu_ctrl, rs, rt, shamt, dest;
        logic        alu_src, shift, mr, mw, rw, m2r, br;
    } ex_m_t;

    logic        clk, rst, flush_i;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_alu_ctrl;
    logic        id_uses_rs, id_uses_rt, id_alu_src, id_reg_dst, id_shift;
    logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic        mem_reg_write, wb_reg_write;
    logic [4:0]  mem_dest, wb_dest;
    logic [31:0] mem_alu_result, wb_data;
    logic        stall_o;
    logic [31:0] ex_pc, ex_data_in1, ex_data_in2, ex_store_data;
    logic [4:0]  ex_alu_ctrl, ex_dest;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;

    int n_tests = 0;
    int n_fail  = 0;
    row_t rows[20];
    int n_rows = 0;

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .id_pc          (id_pc),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_shamt       (id_shamt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_alu_ctrl    (id_alu_ctrl),
        .id_alu_src     (id_alu_src),
        .id_reg_dst     (id_reg_dst),
        .id_shift       (id_shift),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .id_reg_write   (id_reg_write),
        .id_mem_to_reg  (id_mem_to_reg),
        .id_branch      (id_branch),
        .mem_reg_write  (mem_reg_write),
        .mem_dest       (mem_dest),
        .mem_alu_result (mem_alu_result),
        .wb_reg_write   (wb_reg_write),
        .wb_dest        (wb_dest),
        .wb_data        (wb_data),
        .stall_o        (stall_o),
        .ex_pc          (ex_pc),
        .ex_alu_ctrl    (ex_alu_ctrl),
        .ex_data_in1    (ex_data_in1),
        .ex_data_in2    (ex_data_in2),
        .ex_store_data  (ex_store_data),
        .ex_dest        (ex_dest),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_branch      (ex_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vin_t zero_in();
        vin_t v;
        v.flush = 0; v.pc = 0; v.rs_data = 0; v.rt_data = 0; v.imm = 0;
        v.rs = 0; v.rt = 0; v.rd = 0; v.shamt = 0; v.alu_ctrl = 0;
        v.uses_rs = 0; v.uses_rt = 0; v.alu_src = 0; v.reg_dst = 0; v.shift = 0;
        v.mem_read = 0; v.mem_write = 0; v.reg_write = 0; v.mem_to_reg = 0; v.branch = 0;
        v.mem_rw = 0; v.mem_dest = 0; v.mem_res = 0;
        v.wb_rw = 0; v.wb_dest = 0; v.wb_data = 0;
        return v;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.stall = 0; e.d1 = 0; e.d2 = 0; e.sd = 0; e.dest = 0; e.rw = 0; e.mr = 0;
        return e;
    endfunction

    function automatic ex_m_t zero_m();
        ex_m_t m;
        m.pc = 0; m.rs_val = 0; m.rt_val = 0; m.imm = 0; m.alu_ctrl = 0;
        m.rs = 0; m.rt = 0; m.shamt = 0; m.dest = 0;
        m.alu_src = 0; m.shift = 0; m.mr = 0; m.mw = 0; m.rw = 0; m.m2r = 0; m.br = 0;
        return m;
    endfunction

    task automatic add_row(input vin_t v, input exp_t e);
        rows[n_rows].in = v;
        rows[n_rows].ex = e;
        n_rows++;
    endtask

    task automatic drive(input vin_t v);
        flush_i = v.flush; id_pc = v.pc; id_rs_data = v.rs_data; id_rt_data = v.rt_data;
        id_imm = v.imm; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd; id_shamt = v.shamt;
        id_alu_ctrl = v.alu_ctrl; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
        id_alu_src = v.alu_src; id_reg_dst = v.reg_dst; id_shift = v.shift;
        id_mem_read = v.mem_read; id_mem_write = v.mem_write; id_reg_write = v.reg_write;
        id_mem_to_reg = v.mem_to_reg; id_branch = v.branch;
        mem_reg_write = v.mem_rw; mem_dest = v.mem_dest; mem_alu_result = v.mem_res;
        wb_reg_write = v.wb_rw; wb_dest = v.wb_dest; wb_data = v.wb_data;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_stall(input ex_m_t m, input vin_t v);
        logic hit;
        hit = m.mr && (m.rt != 0) &&
              ((v.uses_rs && v.rs == m.rt) || (v.uses_rt && v.rt == m.rt));
        return hit && !v.flush;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] val,
                                          input vin_t v);
        if (a == 0) return val;
        if (v.mem_rw && v.mem_dest == a) return v.mem_res;
        if (v.wb_rw && v.wb_dest == a) return v.wb_data;
        return val;
    endfunction

    function automatic ex_m_t m_next(input ex_m_t m, input vin_t v);
        ex_m_t n;
        n = zero_m();
        if (v.flush || m_stall(m, v)) return n;
        n.pc = v.pc; n.imm = v.imm; n.alu_ctrl = v.alu_ctrl; n.rs = v.rs; n.rt = v.rt;
        n.shamt = v.shamt; n.dest = v.reg_dst ? v.rd : v.rt;
        n.rs_val = (v.wb_rw && v.wb_dest != 0 && v.wb_dest == v.rs) ? v.wb_data : v.rs_data;
        n.rt_val = (v.wb_rw && v.wb_dest != 0 && v.wb_dest == v.rt) ? v.wb_data : v.rt_data;
        n.alu_src = v.alu_src; n.shift = v.shift; n.mr = v.mem_read; n.mw = v.mem_write;
        n.rw = v.reg_write; n.m2r = v.mem_to_reg; n.br = v.branch;
        return n;
    endfunction

    task automatic check_model(input ex_m_t m, input vin_t v);
        logic [31:0] e1, e2, es;
        es = m_fwd(m.rt, m.rt_val, v);
        e1 = m.shift ? {27'b0, m.shamt} : m_fwd(m.rs, m.rs_val, v);
        e2 = m.alu_src ? m.imm : es;
        chk("rnd_stall", {31'b0, stall_o}, {31'b0, m_stall(m, v)});
        chk("rnd_data_in1", ex_data_in1, e1);
        chk("rnd_data_in2", ex_data_in2, e2);
        chk("rnd_store_data", ex_store_data, es);
        chk("rnd_dest", {27'b0, ex_dest}, {27'b0, m.dest});
        chk("rnd_pc", ex_pc, m.pc);
        chk("rnd_alu_ctrl", {27'b0, ex_alu_ctrl}, {27'b0, m.alu_ctrl});
        chk("rnd_ctrls", {27'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
                          ex_branch}, {27'b0, m.mr, m.mw, m.rw, m.m2r, m.br});
    endtask

    function automatic vin_t rand_in();
        vin_t v;
        v = zero_in();
        v.flush = ($urandom_range(0, 7) == 0);
        v.pc = $urandom; v.rs_data = $urandom; v.rt_data = $urandom; v.imm = $urandom;
        v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
        v.rd = 5'($urandom_range(0, 3)); v.shamt = 5'($urandom_range(0, 31));
        v.alu_ctrl = 5'($urandom_range(0, 12));
        v.uses_rs = 1'($urandom_range(0, 1)); v.uses_rt = 1'($urandom_range(0, 1));
        v.alu_src = 1'($urandom_range(0, 1)); v.reg_dst = 1'($urandom_range(0, 1));
        v.shift = ($urandom_range(0, 3) == 0);
        v.mem_read = ($urandom_range(0, 2) == 0);
        v.mem_write = 1'($urandom_range(0, 1)); v.reg_write = 1'($urandom_range(0, 1));
        v.mem_to_reg = 1'($urandom_range(0, 1)); v.branch = 1'($urandom_range(0, 1));
        v.mem_rw = 1'($urandom_range(0, 1)); v.mem_dest = 5'($urandom_range(0, 3));
        v.mem_res = $urandom;
        v.wb_rw = 1'($urandom_range(0, 1)); v.wb_dest = 5'($urandom_range(0, 3));
        v.wb_data = $urandom;
        return v;
    endfunction

    initial begin
        vin_t  v, ins;
        exp_t  e;
        ex_m_t m;

        // Row 0: plain add r3 = r1 + r2; EX still holds the reset bubble.
        v = zero_in(); v.rs = 1; v.rt = 2; v.rs_data = 5; v.rt_data = 7; v.rd = 3;
        v.reg_dst = 1; v.reg_write = 1; v.uses_rs = 1; v.uses_rt = 1; v.alu_ctrl = AluOpAdd;
        e = zero_exp(); add_row(v, e);
        // Row 1: instruction using rs=$4; check plain capture.
        v = zero_in(); v.rs = 4; v.rs_data = 32'h44; v.rt = 5; v.rt_data = 32'h55; v.rd = 6;
        v.reg_dst = 1; v.reg_write = 1; v.uses_rs = 1; v.uses_rt = 1;
        e = zero_exp(); e.d1 = 5; e.d2 = 7; e.sd = 7; e.dest = 3; e.rw = 1; add_row(v, e);
        // Row 2: MEM and WB both target $4 -> MEM wins; same instruction re-captured with WB
        // write-through on rs.
        v.mem_rw = 1; v.mem_dest = 4; v.mem_res = 32'h100;
        v.wb_rw = 1; v.wb_dest = 4; v.wb_data = 32'h200;
        e = zero_exp(); e.d1 = 32'h100; e.d2 = 32'h55; e.sd = 32'h55; e.dest = 6; e.rw = 1;
        add_row(v, e);
        // Row 3: MEM dropped, WB now 0x300 -> forwarded over captured 0x200; ID is lw $8,4($1).
        v = zero_in(); v.rs = 1; v.rs_data = 32'h1000; v.rt = 8; v.rt_data = 32'h77; v.imm = 4;
        v.alu_src = 1; v.mem_read = 1; v.reg_write = 1; v.mem_to_reg = 1; v.uses_rs = 1;
        v.wb_rw = 1; v.wb_dest = 4; v.wb_data = 32'h300;
        e = zero_exp(); e.d1 = 32'h300; e.d2 = 32'h55; e.sd = 32'h55; e.dest = 6; e.rw = 1;
        add_row(v, e);
        // Row 4: add r9 = r8 + r2 behind the load -> stall.
        v = zero_in(); v.rs = 8; v.rs_data = 32'hDEAD; v.rt = 2; v.rt_data = 7; v.rd = 9;
        v.reg_dst = 1; v.reg_write = 1; v.uses_rs = 1; v.uses_rt = 1; v.alu_ctrl = AluOpAdd;
        e = zero_exp(); e.stall = 1; e.d1 = 32'h1000; e.d2 = 4; e.sd = 32'h77; e.dest = 8;
        e.rw = 1; e.mr = 1; add_row(v, e);
        // Row 5: add re-presented, load now in MEM; EX shows the bubble.
        v.mem_rw = 1; v.mem_dest = 8; v.mem_res = 32'hBEEF;
        e = zero_exp(); add_row(v, e);
        // Row 6: add in EX takes $8 from the MEM result.
        v = zero_in(); v.mem_rw = 1; v.mem_dest = 8; v.mem_res = 32'hBEEF;
        e = zero_exp(); e.d1 = 32'hBEEF; e.d2 = 7; e.sd = 7; e.dest = 9; e.rw = 1;
        add_row(v, e);
        // Row 7: instruction reading $0 while MEM claims to write $0.
        v = zero_in(); v.uses_rs = 1; v.reg_write = 1; v.reg_dst = 1; v.rd = 12;
        v.mem_rw = 1; v.mem_dest = 0; v.mem_res = 32'hFFFF;
        e = zero_exp(); add_row(v, e);
        // Row 8: $0 never forwarded; ID is a load into $0.
        v = zero_in(); v.mem_read = 1; v.reg_write = 1; v.alu_src = 1; v.imm = 32'h10;
        v.mem_rw = 1; v.mem_dest = 0; v.mem_res = 32'hFFFF;
        e = zero_exp(); e.dest = 12; e.rw = 1; add_row(v, e);
        // Row 9: load with rt=$0 in EX, ID reads $0 -> no stall. ID is lw $8,8($0).
        v = zero_in(); v.uses_rs = 1; v.rt = 8; v.mem_read = 1; v.reg_write = 1;
        v.alu_src = 1; v.imm = 8;
        e = zero_exp(); e.d2 = 32'h10; e.rw = 1; e.mr = 1; add_row(v, e);
        // Row 10: hazard on $8 but flush wins.
        v = zero_in(); v.flush = 1; v.rs = 8; v.uses_rs = 1; v.reg_write = 1; v.reg_dst = 1;
        v.rd = 13;
        e = zero_exp(); e.d2 = 8; e.dest = 8; e.rw = 1; e.mr = 1; add_row(v, e);
        // Row 11: bubble from flush; ID is sll r10 = r2 << 4.
        v = zero_in(); v.shift = 1; v.shamt = 4; v.rt = 2; v.rt_data = 1; v.uses_rt = 1;
        v.reg_write = 1; v.reg_dst = 1; v.rd = 10; v.alu_ctrl = AluOpSll;
        e = zero_exp(); add_row(v, e);
        // Row 12: shift operands.
        v = zero_in();
        e = zero_exp(); e.d1 = 4; e.d2 = 1; e.sd = 1; e.dest = 10; e.rw = 1; add_row(v, e);
        // Row 13: capture with WB write-through on rs=$9.
        v = zero_in(); v.rs = 9; v.uses_rs = 1; v.reg_write = 1; v.reg_dst = 1; v.rd = 11;
        v.wb_rw = 1; v.wb_dest = 9; v.wb_data = 32'hAA;
        e = zero_exp(); add_row(v, e);
        // Row 14: captured rs holds the write-through value.
        v = zero_in();
        e = zero_exp(); e.d1 = 32'hAA; e.dest = 11; e.rw = 1; add_row(v, e);

        rst = 1'b1;
        drive(zero_in());
        #1;
        chk("reset_stall", {31'b0, stall_o}, 32'd0);
        chk("reset_ctrls", {27'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
                            ex_branch}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < n_rows; i++) begin
            drive(rows[i].in);
            #1;
            chk($sformatf("row%0d_stall", i), {31'b0, stall_o}, {31'b0, rows[i].ex.stall});
            chk($sformatf("row%0d_data_in1", i), ex_data_in1, rows[i].ex.d1);
            chk($sformatf("row%0d_data_in2", i), ex_data_in2, rows[i].ex.d2);
            chk($sformatf("row%0d_store_data", i), ex_store_data, rows[i].ex.sd);
            chk($sformatf("row%0d_dest", i), {27'b0, ex_dest}, {27'b0, rows[i].ex.dest});
            chk($sformatf("row%0d_reg_write", i), {31'b0, ex_reg_write}, {31'b0, rows[i].ex.rw});
            chk($sformatf("row%0d_mem_read", i), {31'b0, ex_mem_read}, {31'b0, rows[i].ex.mr});
            @(posedge clk);
            @(negedge clk);
        end

        // Async reset between edges, then normal capture on the first edge after release.
        ins = zero_in(); ins.pc = 32'h40; ins.rs = 3; ins.rs_data = 32'h1234; ins.uses_rs = 1;
        ins.rt = 5; ins.reg_write = 1; ins.mem_read = 1; ins.alu_ctrl = AluOpAdd;
        drive(ins);
        @(posedge clk);
        #2;
        chk("pre_rst_reg_write", {31'b0, ex_reg_write}, 32'd1);
        chk("pre_rst_data_in1", ex_data_in1, 32'h1234);
        ins.rs = 5; ins.uses_rs = 1; // ID now reads the load target
        drive(ins);
        #1;
        chk("pre_rst_stall", {31'b0, stall_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_data_in1", ex_data_in1, 32'd0);
        chk("rst_dest", {27'b0, ex_dest}, 32'd0);
        chk("rst_ctrls", {27'b0, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
                          ex_branch}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ins.rs = 3;
        drive(ins);
        @(posedge clk);
        #1;
        chk("post_rst_pc", ex_pc, 32'h40);
        chk("post_rst_data_in1", ex_data_in1, 32'h1234);
        chk("post_rst_reg_write", {31'b0, ex_reg_write}, 32'd1);
        m = m_next(zero_m(), ins);
        @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            v = rand_in();
            drive(v);
            #1;
            check_model(m, v);
            @(posedge clk);
            m = m_next(m, v);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
